// File: rtl/afc_sar_fsm.sv
// Automatic frequency calibration controller: binary-search or linear search of a
// VCO band code driven by slow/fast/freeze comparator decisions.
module afc_sar_fsm #(
    parameter int CODE_W     = 5,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_ITER   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [2:0]        comp_in,
    output logic [CODE_W-1:0] code_out,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [CODE_W:0]   state_out
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_DECIDE = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    localparam logic [2:0] COMP_SLOW   = 3'b010;
    localparam logic [2:0] COMP_FAST   = 3'b100;
    localparam logic [2:0] COMP_FREEZE = 3'b001;

    localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam int K_W    = $clog2(CODE_W);

    localparam logic [CODE_W-1:0] CODE_ONE  = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [CODE_W-1:0] CODE_MID  = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] CODE_ONES = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_ZERO = {CODE_W{1'b0}};
    localparam logic [K_W-1:0]    K_TOP     = K_W'(CODE_W - 1);

    logic [2:0]        state_r, state_s;
    logic [CODE_W-1:0] code_r, code_s;
    logic [K_W-1:0]    k_r, k_s;
    logic [ITER_W-1:0] iter_r, iter_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              mode_r, mode_s;
    logic              busy_r, done_r, fail_r;
    logic [CODE_W-1:0] bit_k_s;
    logic [ITER_W-1:0] iter_inc_s;
    logic              slow_s;

    // Next-state, next-code and counter computation.
    always_comb begin
        state_s    = state_r;
        code_s     = code_r;
        k_s        = k_r;
        iter_s     = iter_r;
        cnt_s      = cnt_r;
        mode_s     = mode_r;
        bit_k_s    = CODE_ONE << k_r;
        iter_inc_s = iter_r + ITER_W'(1);
        slow_s     = (comp_in == COMP_SLOW);

        case (state_r)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_s = ST_SETTLE;
                    code_s  = CODE_MID;
                    k_s     = K_TOP;
                    iter_s  = {ITER_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    mode_s  = mode;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_DECIDE;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_DECIDE: begin
                case (comp_in)
                    COMP_FREEZE: state_s = ST_DONE;
                    COMP_SLOW, COMP_FAST: begin
                        if (!mode_r) begin
                            // Resolve bit k, then trial-set the next lower bit.
                            code_s = slow_s ? code_r : (code_r & ~bit_k_s);
                            if (k_r != {K_W{1'b0}}) begin
                                code_s  = code_s | (bit_k_s >> 1);
                                k_s     = k_r - K_W'(1);
                                state_s = ST_SETTLE;
                            end else begin
                                state_s = ST_DONE;
                            end
                        end else if ((slow_s && (code_r == CODE_ONES)) ||
                                     (!slow_s && (code_r == CODE_ZERO))) begin
                            state_s = ST_FAIL;
                        end else begin
                            code_s  = slow_s ? (code_r + CODE_ONE) : (code_r - CODE_ONE);
                            iter_s  = iter_inc_s;
                            state_s = (iter_inc_s == ITER_W'(MAX_ITER)) ? ST_FAIL : ST_SETTLE;
                        end
                    end
                    default: state_s = ST_SETTLE;
                endcase
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and status registers; status flags follow the next state so they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            code_r  <= CODE_MID;
            k_r     <= K_TOP;
            iter_r  <= {ITER_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            mode_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fail_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            code_r  <= code_s;
            k_r     <= k_s;
            iter_r  <= iter_s;
            cnt_r   <= cnt_s;
            mode_r  <= mode_s;
            busy_r  <= (state_s == ST_SETTLE) || (state_s == ST_DECIDE);
            done_r  <= (state_s == ST_DONE);
            fail_r  <= (state_s == ST_FAIL);
        end
    end

    assign code_out  = code_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fail      = fail_r;
    assign state_out = {done_r, code_r};

endmodule
